// File: rtl/reduceron_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// reduceron_io_ctrl_if
// Core-side IO bus between the Reduceron core and reduceron_io_ctrl.
//   ioaddr      15  IO address, valid with a strobe
//   iowrite      1  one-cycle write strobe
//   ioread       1  one-cycle read strobe
//   iowd        15  write data
//   iord        15  read data back to the core
//   iord_valid   1  one-cycle pulse, iord valid
//   io_stall     1  core must not strobe while high
// master = core side, slave = IO controller side.
// -----------------------------------------------------------------------------
interface reduceron_io_ctrl_if;
   logic [14:0] ioaddr;
   logic        iowrite;
   logic        ioread;
   logic [14:0] iowd;
   logic [14:0] iord;
   logic        iord_valid;
   logic        io_stall;

   modport master (
      output ioaddr, iowrite, ioread, iowd,
      input  iord, iord_valid, io_stall
   );

   modport slave (
      input  ioaddr, iowrite, ioread, iowd,
      output iord, iord_valid, io_stall
   );
endinterface

// File: rtl/reduceron_io_ctrl.sv
// -----------------------------------------------------------------------------
// reduceron_io_ctrl
// Bridges the Reduceron core IO port to a byte-wide TX sink and RX source.
// Writes to address 0 are buffered in a TX FIFO; address 1 is a blocking RX
// read; address 2 returns {rx_valid, tx_full}. When a write meets a full FIFO
// or a read finds no RX byte, the controller stalls the core until the
// operation can complete.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   core (slave)        core IO bus (see reduceron_io_ctrl_if)
//   tx_data/tx_valid    FIFO head byte / FIFO non-empty
//   tx_ready            head consumed when tx_valid & tx_ready
//   rx_data/rx_valid    received byte / byte available
//   rx_ready            byte consumed when rx_valid & rx_ready
//
// Optional build macro IO_STALL_COUNT_EN: adds a 16-bit saturating counter of
// stalled cycles, readable (low 15 bits) and clearable at address 3. Without
// it, address 3 is unmapped.
// -----------------------------------------------------------------------------
module reduceron_io_ctrl #(
   parameter int TX_DEPTH = 16,
   parameter int TX_AW    = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   reduceron_io_ctrl_if.slave     core,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready
);

   typedef enum logic [1:0] {IDLE, TX_WAIT, RX_WAIT} state_t;

   localparam logic [TX_AW:0] DEPTH = (TX_AW+1)'(TX_DEPTH);

   state_t            state, state_nxt;

   logic [7:0]        mem [TX_DEPTH];
   logic [TX_AW-1:0]  wptr, rptr;
   logic [TX_AW:0]    count;
   logic              tx_full;
   logic              push, pop;
   logic [7:0]        push_byte;

   logic [7:0]        pend_byte;
   logic              pend_ld;

   logic [14:0]       iord_r;
   logic              iord_valid_r;
   logic              rd_ld;
   logic [14:0]       rd_word;
   logic              stall;

`ifdef IO_STALL_COUNT_EN
   logic [15:0]       stall_cnt;
   logic              cnt_clr;
`endif

   assign stall           = (state != IDLE);
   assign tx_full         = (count == DEPTH);
   assign tx_valid        = (count != '0);
   assign tx_data         = mem[rptr];
   assign pop             = tx_valid && tx_ready;
   assign core.io_stall   = stall;
   assign core.iord       = iord_r;
   assign core.iord_valid = iord_valid_r;

   // Next-state and per-cycle actions. Strobes are only looked at in IDLE,
   // which is exactly the io_stall=0 condition. A write strobe masks a read.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_byte = 8'h00;
      pend_ld   = 1'b0;
      rx_ready  = 1'b0;
      rd_ld     = 1'b0;
      rd_word   = 15'h0000;
`ifdef IO_STALL_COUNT_EN
      cnt_clr   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (core.iowrite) begin
               if (core.ioaddr == 15'd0) begin
                  // Full-check uses the registered count: a pop this cycle
                  // does not rescue the write, it still goes to TX_WAIT.
                  if (!tx_full) begin
                     push      = 1'b1;
                     push_byte = core.iowd[7:0];
                  end else begin
                     pend_ld   = 1'b1;
                     state_nxt = TX_WAIT;
                  end
               end
`ifdef IO_STALL_COUNT_EN
               else if (core.ioaddr == 15'd3) begin
                  cnt_clr = 1'b1;
               end
`endif
            end else if (core.ioread) begin
               case (core.ioaddr)
                  15'd1: begin
                     if (rx_valid) begin
                        rx_ready = 1'b1;
                        rd_ld    = 1'b1;
                        rd_word  = {7'b0, rx_data};
                     end else begin
                        state_nxt = RX_WAIT;
                     end
                  end
                  15'd2: begin
                     rd_ld   = 1'b1;
                     rd_word = {13'b0, rx_valid, tx_full};
                  end
`ifdef IO_STALL_COUNT_EN
                  15'd3: begin
                     rd_ld   = 1'b1;
                     rd_word = stall_cnt[14:0];
                  end
`endif
                  default: begin
                     rd_ld = 1'b1;
                  end
               endcase
            end
         end
         TX_WAIT: begin
            if (!tx_full) begin
               push      = 1'b1;
               push_byte = pend_byte;
               state_nxt = IDLE;
            end
         end
         RX_WAIT: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               rd_ld     = 1'b1;
               rd_word   = {7'b0, rx_data};
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control state: FSM, FIFO pointers/count, read port, pending byte
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         iord_r       <= 15'h0000;
         iord_valid_r <= 1'b0;
         pend_byte    <= 8'h00;
      end else begin
         state        <= state_nxt;
         iord_valid_r <= rd_ld;
         if (rd_ld) begin
            iord_r <= rd_word;
         end
         if (pend_ld) begin
            pend_byte <= core.iowd[7:0];
         end
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage is data only and is left unreset
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wptr] <= push_byte;
      end
   end

`ifdef IO_STALL_COUNT_EN
   // Saturating stall counter; sticks at 16'hFFFF until cleared
   always_ff @(posedge clock) begin
      if (reset || cnt_clr) begin
         stall_cnt <= 16'h0000;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'h0001;
      end
   end
`endif

endmodule
